lcd_hd44780_ctrl: RTL

//  Hardware HD44780 8-bit LCD driver replacing software bit-banging of data/en/rs/rw PIOs.

---
 rtl/lcd_hd44780_ctrl_if.sv | 28 ++
 rtl/lcd_hd44780_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_hd44780_ctrl_if
//  Description : Command byte handshake between a bus master and the
//                HD44780 controller (valid/ready, register select, data).
//  Revision    : 1.0  initial release
// ============================================================================
interface lcd_hd44780_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_rs,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_rs,
        input  cmd_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_hd44780_ctrl
//  Description : HD44780 8-bit write-only LCD bus driver. Accepts bytes over
//                a valid/ready port, generates setup/enable/hold timing and
//                the per-command execution wait. With LCD_AUTO_INIT_EN
//                defined it also runs the power-on init sequence itself.
//  Options     : LCD_AUTO_INIT_EN  (undefined: no power-up wait, no init)
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_hd44780_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SETUP_CYC   = 4,
    parameter int EN_PULSE_NS = 460,
    parameter int HOLD_CYC    = 2,
    parameter int SHORT_US    = 40,
    parameter int LONG_US     = 1640,
    parameter int POWERUP_MS  = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    lcd_hd44780_ctrl_if.slave    cmd,
    output logic [7:0]           lcd_data,
    output logic                 lcd_en,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 init_done
);

    // Cycle counts, rounded up, never below one cycle.
    localparam longint c_hz        = longint'(CLK_HZ);
    localparam longint c_setup_raw = longint'(SETUP_CYC);
    localparam longint c_hold_raw  = longint'(HOLD_CYC);
    localparam longint c_en_raw    = (c_hz * EN_PULSE_NS + 999_999_999) / 1_000_000_000;
    localparam longint c_short_raw = (c_hz * SHORT_US + 999_999) / 1_000_000;
    localparam longint c_long_raw  = (c_hz * LONG_US + 999_999) / 1_000_000;
    localparam longint c_pwrup_raw = (c_hz * POWERUP_MS + 999) / 1_000;

    localparam longint c_setup_cyc = (c_setup_raw < 1) ? 1 : c_setup_raw;
    localparam longint c_hold_cyc  = (c_hold_raw  < 1) ? 1 : c_hold_raw;
    localparam longint c_en_cyc    = (c_en_raw    < 1) ? 1 : c_en_raw;
    localparam longint c_short_cyc = (c_short_raw < 1) ? 1 : c_short_raw;
    localparam longint c_long_cyc  = (c_long_raw  < 1) ? 1 : c_long_raw;
    localparam longint c_pwrup_cyc = (c_pwrup_raw < 1) ? 1 : c_pwrup_raw;

    localparam longint c_max_a = (c_setup_cyc > c_hold_cyc) ? c_setup_cyc : c_hold_cyc;
    localparam longint c_max_b = (c_en_cyc > c_short_cyc) ? c_en_cyc : c_short_cyc;
    localparam longint c_max_c = (c_long_cyc > c_pwrup_cyc) ? c_long_cyc : c_pwrup_cyc;
    localparam longint c_max_d = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam longint c_max   = (c_max_c > c_max_d) ? c_max_c : c_max_d;
    localparam int     c_cnt_w = $clog2(c_max) + 1;

    // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
    localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(c_setup_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_en_ld    = c_cnt_w'(c_en_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(c_hold_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_short_ld = c_cnt_w'(c_short_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_long_ld  = c_cnt_w'(c_long_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_pwrup_ld = c_cnt_w'(c_pwrup_cyc - 1);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_SETUP = 3'd3,
        ST_PULSE = 3'd4,
        ST_HOLD  = 3'd5,
        ST_WAIT  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_load_cmd;
    logic                 w_is_long;
    logic                 r_rs;
    logic [7:0]           r_data;
    logic                 r_en;
    logic                 r_init_done;

`ifdef LCD_AUTO_INIT_EN
    localparam logic [2:0] c_init_len = 3'd6;
    logic                 w_load_init;
    logic [2:0]           r_init_idx;

    // Function set 8-bit/2-line (x3), display on, clear, entry mode inc.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction
`endif

    // Clear and return-home need the long execution time.
    assign w_is_long = ~r_rs & ((r_data == 8'h01) | (r_data == 8'h02) | (r_data == 8'h03));

    // State and phase counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_PWRUP;
            r_cnt   <= c_pwrup_ld;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter reload and byte-load strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_cmd  = 1'b0;
`ifdef LCD_AUTO_INIT_EN
        w_load_init = 1'b0;
`endif
        case (r_state)
            ST_PWRUP: begin
`ifdef LCD_AUTO_INIT_EN
                if (r_cnt == '0) w_state_nxt = ST_INIT;
                else             w_cnt_nxt   = r_cnt - 1'b1;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_INIT: begin
`ifdef LCD_AUTO_INIT_EN
                w_load_init = 1'b1;
                w_state_nxt = ST_SETUP;
                w_cnt_nxt   = c_setup_ld;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_load_cmd  = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_setup_ld;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = c_en_ld;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = w_is_long ? c_long_ld : c_short_ld;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
`ifdef LCD_AUTO_INIT_EN
                    w_state_nxt = (r_init_idx != c_init_len) ? ST_INIT : ST_IDLE;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_PWRUP;
            end
        endcase
    end

    // Bus output registers: byte latch, glitch-free enable and init flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_init_done <= 1'b0;
`ifdef LCD_AUTO_INIT_EN
            r_init_idx  <= 3'd0;
`endif
        end else begin
            if (w_load_cmd) begin
                r_rs   <= cmd.cmd_rs;
                r_data <= cmd.cmd_data;
            end
`ifdef LCD_AUTO_INIT_EN
            else if (w_load_init) begin
                r_rs       <= 1'b0;
                r_data     <= init_byte(r_init_idx);
                r_init_idx <= r_init_idx + 3'd1;
            end
`endif
            r_en <= (w_state_nxt == ST_PULSE);
            if (w_state_nxt == ST_IDLE) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign lcd_data      = r_data;
    assign lcd_rs        = r_rs;
    assign lcd_en        = r_en;
    assign lcd_rw        = 1'b0;
    assign init_done     = r_init_done;

endmodule
`default_nettype wire
